// File: rtl/truth_sweep.sv
// Exhaustive truth-table sweep engine: steps vec through 0..2^N_IN-1, holds each
// vector SETTLE cycles, captures z into truth_table and counts the ones.
// The captured table port is truth_table because `table` is a reserved word.
module truth_sweep #(
  parameter int unsigned N_IN   = 5,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   z,
  output logic [N_IN-1:0]        vec,
  output logic [(1<<N_IN)-1:0]   truth_table,
  output logic [N_IN:0]          ones_cnt,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [N_IN-1:0] LAST_IDX  = '1;
  localparam logic [7:0]      WCNT_INIT = 8'(SETTLE - 1);

  logic [1:0]      state;
  logic [N_IN-1:0] idx;
  logic [7:0]      wcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      truth_table <= '0;
      ones_cnt    <= '0;
      idx         <= '0;
      wcnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            truth_table <= '0;
            ones_cnt    <= '0;
            idx         <= '0;
            wcnt        <= WCNT_INIT;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (wcnt != 8'd0) begin
            wcnt <= wcnt - 8'd1;
          end else begin
            truth_table[idx] <= z;
            ones_cnt         <= ones_cnt + (N_IN+1)'(z);
            // Terminal compare comes first so idx never wraps past the last vector.
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx  <= idx + N_IN'(1);
              wcnt <= WCNT_INIT;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == HOLD);
    done = (state == DONE);
    vec  = busy ? idx : '0;
  end

endmodule

// File: tb/tb_truth_sweep.sv
// Bench for truth_sweep: three instances (5/1, 3/2, 8/1) driving simple gate models,
// table-driven sweeps checked through an expected-result queue plus corner sequences.
module tb_truth_sweep;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] start_m;
  logic [2:0] z_m;
  int mode_m [3];

  logic [4:0]   vec5;  logic [31:0]  tt5;  logic [5:0] ones5; logic busy5, done5;
  logic [2:0]   vec3;  logic [7:0]   tt3;  logic [3:0] ones3; logic busy3, done3;
  logic [7:0]   vec8;  logic [255:0] tt8;  logic [8:0] ones8; logic busy8, done8;

  logic [7:0]   vec_m  [3];
  logic [255:0] tt_m   [3];
  logic [8:0]   ones_m [3];
  logic [2:0]   busy_m, done_m;

  int checks = 0;
  int passed = 0;

  typedef struct { logic [255:0] tt; int ones; } exp_t;
  typedef struct { int inst; int mode; logic [255:0] tt; int ones; } vec_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  truth_sweep #(.N_IN(5), .SETTLE(1)) u5 (
    .clk(clk), .rst_n(rst_n), .start(start_m[0]), .z(z_m[0]), .vec(vec5),
    .truth_table(tt5), .ones_cnt(ones5), .busy(busy5), .done(done5));
  truth_sweep #(.N_IN(3), .SETTLE(2)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_m[1]), .z(z_m[1]), .vec(vec3),
    .truth_table(tt3), .ones_cnt(ones3), .busy(busy3), .done(done3));
  truth_sweep #(.N_IN(8), .SETTLE(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start_m[2]), .z(z_m[2]), .vec(vec8),
    .truth_table(tt8), .ones_cnt(ones8), .busy(busy8), .done(done8));

  function automatic int n_of(input int inst);
    return (inst == 0) ? 5 : (inst == 1) ? 3 : 8;
  endfunction

  function automatic int s_of(input int inst);
    return (inst == 1) ? 2 : 1;
  endfunction

  // Gate models: 0 xor, 1 and, 2 or, 3 const0, 4 const1, 5 first input (a)
  function automatic logic zf(input int mode, input logic [7:0] v, input int n);
    case (mode)
      0:       return ^v;
      1:       return v == 8'((1 << n) - 1);
      2:       return |v;
      4:       return 1'b1;
      5:       return v[n-1];
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    vec_m[0]  = 8'(vec5);   vec_m[1]  = 8'(vec3);   vec_m[2]  = vec8;
    tt_m[0]   = 256'(tt5);  tt_m[1]   = 256'(tt3);  tt_m[2]   = tt8;
    ones_m[0] = 9'(ones5);  ones_m[1] = 9'(ones3);  ones_m[2] = ones8;
    busy_m    = {busy8, busy3, busy5};
    done_m    = {done8, done3, done5};
    z_m[0]    = zf(mode_m[0], vec_m[0], 5);
    z_m[1]    = zf(mode_m[1], vec_m[1], 3);
    z_m[2]    = zf(mode_m[2], vec_m[2], 8);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // One sweep on instance inst; optional extra start pulse while vector restart_at is on vec.
  task automatic sweep(input int inst, input int mode, input logic [255:0] ett,
                       input int eones, input int restart_at);
    int n, s, cyc, bad_vec, budget;
    exp_t e, got;
    n = n_of(inst);
    s = s_of(inst);
    budget = (1 << n) * s + 10;
    mode_m[inst] = mode;
    @(negedge clk);
    start_m[inst] = 1'b1;
    e.tt = ett; e.ones = eones;
    sb.push_back(e);
    @(negedge clk);
    start_m[inst] = 1'b0;
    check("clear_at_accept", {tt_m[inst], 247'(ones_m[inst])}, '0);
    cyc = 1;
    bad_vec = 0;
    while (!done_m[inst] && cyc < budget) begin
      if (busy_m[inst] !== 1'b1 || vec_m[inst] !== 8'((cyc - 1) / s)) bad_vec++;
      start_m[inst] = (restart_at >= 0 && cyc == restart_at * s + 1);
      @(negedge clk);
      start_m[inst] = 1'b0;
      cyc++;
    end
    check("vec_step", 256'(bad_vec), 256'(0));
    check("latency", 256'(cyc - 1), 256'((1 << n) * s));
    check("busy_at_done", 256'(busy_m[inst]), 256'(0));
    got.tt = tt_m[inst];
    got.ones = int'(ones_m[inst]);
    e = sb.pop_front();
    check("table", got.tt, e.tt);
    check("ones_cnt", 256'(got.ones), 256'(e.ones));
    @(negedge clk);
    check("done_pulse", {255'(0), done_m[inst]}, 256'(0));
    check("table_hold", tt_m[inst], ett);
  endtask

  task automatic wait_done(input int inst, output int cyc);
    cyc = 0;
    while (!done_m[inst] && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    vec_t vt [6];
    int cyc;
    vt[0] = '{0, 0, 256'h96696996, 16};
    vt[1] = '{0, 1, 256'h80000000, 1};
    vt[2] = '{0, 5, 256'hFFFF0000, 16};
    vt[3] = '{1, 2, 256'hFE, 7};
    vt[4] = '{2, 4, {256{1'b1}}, 256};
    vt[5] = '{2, 3, 256'h0, 0};

    rst_n = 1'b0;
    start_m = '0;
    for (int i = 0; i < 3; i++) mode_m[i] = 0;
    @(negedge clk);
    @(negedge clk);
    check("reset_u5", {tt5, 5'(vec5), 6'(ones5), busy5, done5}, '0);
    check("reset_u8", {tt8[246:0], vec8, ones8}, {busy8, done8, 254'(0)});
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) sweep(vt[i].inst, vt[i].mode, vt[i].tt, vt[i].ones, -1);

    // Extra start at vector 10 is ignored
    sweep(0, 0, 256'h96696996, 16, 10);

    // start held high: back-to-back sweeps separated by one DONE cycle
    mode_m[0] = 0;
    @(negedge clk);
    start_m[0] = 1'b1;
    wait_done(0, cyc);
    check("b2b_first_done", 256'(cyc), 256'(33));
    @(negedge clk);
    check("b2b_idle_gap", {254'(0), busy5, done5}, 256'(0));
    @(negedge clk);
    check("b2b_reaccept", {250'(0), busy5, vec5}, {250'(0), 1'b1, 5'd0});
    wait_done(0, cyc);
    start_m[0] = 1'b0;
    check("b2b_latency", 256'(cyc), 256'(32));
    check("b2b_table", 256'(tt5), 256'h96696996);

    // Asynchronous reset at vector 17, mid-clock
    @(negedge clk);
    start_m[0] = 1'b1;
    @(negedge clk);
    start_m[0] = 1'b0;
    cyc = 0;
    while (vec5 != 5'd17 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_reset_vec", 256'(vec5), 256'(17));
    #2 rst_n = 1'b0;
    #1 check("async_reset", {tt5, 5'(vec5), 6'(ones5), busy5, done5}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(0, 0, 256'h96696996, 16, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
